// File: rtl/decode_sequencer_pkg.sv
// Shared state definitions for the decode sequencer: FSM states, SRAM grant
// encoding and the default per-stage watchdog limit.
package decode_sequencer_pkg;

    // 0.2 s at 50 MHz; long enough for any single decode stage to finish
    localparam logic [23:0] SEQ_TIMEOUT_DEFAULT = 24'd10_000_000;

    typedef enum logic [2:0] {
        S_SEQ_IDLE     = 3'd0,
        S_SEQ_M2_START = 3'd1,
        S_SEQ_M2_RUN   = 3'd2,
        S_SEQ_M2_DRAIN = 3'd3,
        S_SEQ_M1_START = 3'd4,
        S_SEQ_M1_RUN   = 3'd5,
        S_SEQ_M1_DRAIN = 3'd6,
        S_SEQ_DONE     = 3'd7
    } seq_state_type;

    // Encoding doubles as the externally visible seq_stage value
    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_M2   = 2'd1,
        GRANT_M1   = 2'd2
    } seq_grant_type;

endpackage

// File: rtl/decode_sequencer_sram_port_mux.sv
// Routes the granted requester onto the single SRAM port. With no grant the
// port is parked: no write, zero address and zero data.
module sram_port_mux
    import decode_sequencer_pkg::*;
(
    input  seq_grant_type i_grant,
    input  logic [17:0]   i_M2Address,
    input  logic [15:0]   i_M2WriteData,
    input  logic          i_M2WeN,
    input  logic [17:0]   i_M1Address,
    input  logic [15:0]   i_M1WriteData,
    input  logic          i_M1WeN,
    output logic [17:0]   o_address,
    output logic [15:0]   o_writeData,
    output logic          o_weN
);

    // Select the bus of the granted requester; anything else stays idle
    always_comb begin
        o_address   = 18'd0;
        o_writeData = 16'd0;
        o_weN       = 1'b1;
        case (i_grant)
            GRANT_M2: begin
                o_address   = i_M2Address;
                o_writeData = i_M2WriteData;
                o_weN       = i_M2WeN;
            end
            GRANT_M1: begin
                o_address   = i_M1Address;
                o_writeData = i_M1WriteData;
                o_weN       = i_M1WeN;
            end
            default: begin
                o_address   = 18'd0;
                o_writeData = 16'd0;
                o_weN       = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_sequencer.sv
// Runs one decode as M2 followed by M1 (or M1 alone when M2 is skipped),
// hands the SRAM port to whichever stage is active and aborts a stage that
// stalls past the watchdog limit.
module decode_sequencer
    import decode_sequencer_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = SEQ_TIMEOUT_DEFAULT
) (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        seq_start,
    input  logic        skip_M2,
    output logic        M2_start,
    output logic        M1_start,
    input  logic        M2_done,
    input  logic        M1_done,
    input  logic [17:0] M2_SRAM_address,
    input  logic [17:0] M1_SRAM_address,
    input  logic [15:0] M2_SRAM_write_data,
    input  logic [15:0] M1_SRAM_write_data,
    input  logic        M2_SRAM_we_n,
    input  logic        M1_SRAM_we_n,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        seq_busy,
    output logic        seq_done,
    output logic        seq_error,
    output logic [1:0]  seq_stage
);

    seq_state_type r_state;
    seq_grant_type r_grant;
    logic [23:0]   r_watchdog;
    logic          r_M2DonePrev;
    logic          r_M1DonePrev;
    logic          r_M2Start;
    logic          r_M1Start;
    logic          r_busy;
    logic          r_seqDone;
    logic          r_seqError;

    logic [23:0]   w_watchdogNext;
    logic          w_M2DoneEdge;
    logic          w_M1DoneEdge;
    logic          w_timeout;

    // A done level left high by an earlier run must not count as completion
    assign w_M2DoneEdge   = M2_done & ~r_M2DonePrev;
    assign w_M1DoneEdge   = M1_done & ~r_M1DonePrev;
    assign w_watchdogNext = r_watchdog + 24'd1;
    assign w_timeout      = (w_watchdogNext >= TIMEOUT_CYCLES);

    // Sequencer FSM with watchdog, grant and all status outputs registered
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            r_state      <= S_SEQ_IDLE;
            r_grant      <= GRANT_NONE;
            r_watchdog   <= 24'd0;
            r_M2DonePrev <= 1'b0;
            r_M1DonePrev <= 1'b0;
            r_M2Start    <= 1'b0;
            r_M1Start    <= 1'b0;
            r_busy       <= 1'b0;
            r_seqDone    <= 1'b0;
            r_seqError   <= 1'b0;
        end else begin
            r_M2DonePrev <= M2_done;
            r_M1DonePrev <= M1_done;
            r_M2Start    <= 1'b0;
            r_M1Start    <= 1'b0;
            r_seqDone    <= 1'b0;
            case (r_state)
                S_SEQ_IDLE: begin
                    if (seq_start) begin
                        r_seqError <= 1'b0;
                        r_watchdog <= 24'd0;
                        r_busy     <= 1'b1;
                        if (skip_M2) begin
                            r_state   <= S_SEQ_M1_START;
                            r_grant   <= GRANT_M1;
                            r_M1Start <= 1'b1;
                        end else begin
                            r_state   <= S_SEQ_M2_START;
                            r_grant   <= GRANT_M2;
                            r_M2Start <= 1'b1;
                        end
                    end
                end
                S_SEQ_M2_START: begin
                    r_state <= S_SEQ_M2_RUN;
                end
                S_SEQ_M2_RUN: begin
                    if (w_M2DoneEdge) begin
                        r_state <= S_SEQ_M2_DRAIN;
                    end else if (w_timeout) begin
                        r_state    <= S_SEQ_IDLE;
                        r_grant    <= GRANT_NONE;
                        r_busy     <= 1'b0;
                        r_seqError <= 1'b1;
                    end else begin
                        r_watchdog <= w_watchdogNext;
                    end
                end
                S_SEQ_M2_DRAIN: begin
                    r_state    <= S_SEQ_M1_START;
                    r_grant    <= GRANT_M1;
                    r_watchdog <= 24'd0;
                    r_M1Start  <= 1'b1;
                end
                S_SEQ_M1_START: begin
                    r_state <= S_SEQ_M1_RUN;
                end
                S_SEQ_M1_RUN: begin
                    if (w_M1DoneEdge) begin
                        r_state <= S_SEQ_M1_DRAIN;
                    end else if (w_timeout) begin
                        r_state    <= S_SEQ_IDLE;
                        r_grant    <= GRANT_NONE;
                        r_busy     <= 1'b0;
                        r_seqError <= 1'b1;
                    end else begin
                        r_watchdog <= w_watchdogNext;
                    end
                end
                S_SEQ_M1_DRAIN: begin
                    r_state   <= S_SEQ_DONE;
                    r_grant   <= GRANT_NONE;
                    r_seqDone <= 1'b1;
                end
                S_SEQ_DONE: begin
                    r_state <= S_SEQ_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_SEQ_IDLE;
                    r_grant <= GRANT_NONE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign M2_start  = r_M2Start;
    assign M1_start  = r_M1Start;
    assign seq_busy  = r_busy;
    assign seq_done  = r_seqDone;
    assign seq_error = r_seqError;
    assign seq_stage = r_grant;

    sram_port_mux u_sramPortMux (
        .i_grant       (r_grant),
        .i_M2Address   (M2_SRAM_address),
        .i_M2WriteData (M2_SRAM_write_data),
        .i_M2WeN       (M2_SRAM_we_n),
        .i_M1Address   (M1_SRAM_address),
        .i_M1WriteData (M1_SRAM_write_data),
        .i_M1WeN       (M1_SRAM_we_n),
        .o_address     (SRAM_address),
        .o_writeData   (SRAM_write_data),
        .o_weN         (SRAM_we_n)
    );

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer: a default-timeout instance exercises
// normal, bypass, stale-done, isolation and reset behaviour; a second instance
// with a 100-cycle watchdog covers timeout and done-versus-timeout priority.
module tb_decode_sequencer;

    logic        CLOCK_50_I = 1'b0;
    logic        Resetn;
    logic        seqStart;
    logic        skipM2;
    logic        M2Done;
    logic        M1Done;
    logic [17:0] m2Addr;
    logic [17:0] m1Addr;
    logic [15:0] m2Data;
    logic [15:0] m1Data;
    logic        m2WeN;
    logic        m1WeN;

    logic        M2_start;
    logic        M1_start;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        seq_busy;
    logic        seq_done;
    logic        seq_error;
    logic [1:0]  seq_stage;

    logic        toStart;
    logic        toM2Done;
    logic        toM1Done;
    logic        toM2Start;
    logic        toM1Start;
    logic [17:0] toAddress;
    logic [15:0] toWriteData;
    logic        toWeN;
    logic        toBusy;
    logic        toDone;
    logic        toError;
    logic [1:0]  toStage;

    int compareCount  = 0;
    int mismatchCount = 0;

    int m2StartSeen = 0;
    int m1StartSeen = 0;
    int doneSeen    = 0;
    int stage1Seen  = 0;
    int toDoneSeen  = 0;

    int m2Before;
    int m1Before;
    int doneBefore;
    int stage1Before;
    int toDoneBefore;

    always #10 CLOCK_50_I = ~CLOCK_50_I;

    decode_sequencer dut (
        .CLOCK_50_I         (CLOCK_50_I),
        .Resetn             (Resetn),
        .seq_start          (seqStart),
        .skip_M2            (skipM2),
        .M2_start           (M2_start),
        .M1_start           (M1_start),
        .M2_done            (M2Done),
        .M1_done            (M1Done),
        .M2_SRAM_address    (m2Addr),
        .M1_SRAM_address    (m1Addr),
        .M2_SRAM_write_data (m2Data),
        .M1_SRAM_write_data (m1Data),
        .M2_SRAM_we_n       (m2WeN),
        .M1_SRAM_we_n       (m1WeN),
        .SRAM_address       (SRAM_address),
        .SRAM_write_data    (SRAM_write_data),
        .SRAM_we_n          (SRAM_we_n),
        .seq_busy           (seq_busy),
        .seq_done           (seq_done),
        .seq_error          (seq_error),
        .seq_stage          (seq_stage)
    );

    decode_sequencer #(.TIMEOUT_CYCLES(24'd100)) dutTo (
        .CLOCK_50_I         (CLOCK_50_I),
        .Resetn             (Resetn),
        .seq_start          (toStart),
        .skip_M2            (1'b0),
        .M2_start           (toM2Start),
        .M1_start           (toM1Start),
        .M2_done            (toM2Done),
        .M1_done            (toM1Done),
        .M2_SRAM_address    (m2Addr),
        .M1_SRAM_address    (m1Addr),
        .M2_SRAM_write_data (m2Data),
        .M1_SRAM_write_data (m1Data),
        .M2_SRAM_we_n       (m2WeN),
        .M1_SRAM_we_n       (m1WeN),
        .SRAM_address       (toAddress),
        .SRAM_write_data    (toWriteData),
        .SRAM_we_n          (toWeN),
        .seq_busy           (toBusy),
        .seq_done           (toDone),
        .seq_error          (toError),
        .seq_stage          (toStage)
    );

    // Count pulses and stage occupancy mid-cycle so each test can diff them
    always @(negedge CLOCK_50_I) begin
        if (M2_start) m2StartSeen = m2StartSeen + 1;
        if (M1_start) m1StartSeen = m1StartSeen + 1;
        if (seq_done) doneSeen = doneSeen + 1;
        if (seq_stage == 2'd1) stage1Seen = stage1Seen + 1;
        if (toDone) toDoneSeen = toDoneSeen + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount = compareCount + 1;
        if (actual !== expected) begin
            mismatchCount = mismatchCount + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [17:0] a2, input logic [15:0] d2, input logic w2,
                                 input logic [17:0] a1, input logic [15:0] d1, input logic w1);
        m2Addr = a2;
        m2Data = d2;
        m2WeN  = w2;
        m1Addr = a1;
        m1Data = d1;
        m1WeN  = w1;
        #1;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge CLOCK_50_I);
        #1;
    endtask

    initial begin
        Resetn   = 1'b0;
        seqStart = 1'b0;
        skipM2   = 1'b0;
        M2Done   = 1'b0;
        M1Done   = 1'b0;
        toStart  = 1'b0;
        toM2Done = 1'b0;
        toM1Done = 1'b0;
        applyStimulus(18'h00111, 16'h1111, 1'b0, 18'h00222, 16'h2222, 1'b0);

        // Reset values, with both requesters trying to write
        stepCycles(3);
        checkOutput("rstM2Start", M2_start, 0);
        checkOutput("rstM1Start", M1_start, 0);
        checkOutput("rstBusy", seq_busy, 0);
        checkOutput("rstDone", seq_done, 0);
        checkOutput("rstError", seq_error, 0);
        checkOutput("rstStage", seq_stage, 0);
        checkOutput("rstWeN", SRAM_we_n, 1);
        checkOutput("rstAddr", SRAM_address, 0);
        checkOutput("rstData", SRAM_write_data, 0);

        // Release of reset: no start pulse, no write
        Resetn = 1'b1;
        stepCycles(2);
        checkOutput("relM2Start", M2_start, 0);
        checkOutput("relM1Start", M1_start, 0);
        checkOutput("relWeN", SRAM_we_n, 1);
        checkOutput("relBusy", seq_busy, 0);

        // Normal run: M2 then M1
        m2Before = m2StartSeen; m1Before = m1StartSeen; doneBefore = doneSeen;
        seqStart = 1'b1;
        skipM2   = 1'b0;
        stepCycles(1);
        checkOutput("normM2Pulse", M2_start, 1);
        checkOutput("normStageM2", seq_stage, 1);
        checkOutput("normBusy", seq_busy, 1);
        seqStart = 1'b0;
        stepCycles(1);
        checkOutput("normM2PulseEnd", M2_start, 0);
        applyStimulus(18'h00ABC, 16'h1234, 1'b0, 18'h3FFFF, 16'hFFFF, 1'b0);
        checkOutput("normM2Addr", SRAM_address, 32'h00ABC);
        checkOutput("normM2Data", SRAM_write_data, 32'h1234);
        checkOutput("normM2We", SRAM_we_n, 0);
        applyStimulus(18'h00ABC, 16'h1234, 1'b1, 18'h3FFFF, 16'hFFFF, 1'b0);
        checkOutput("normM1Blocked", SRAM_we_n, 1);
        stepCycles(499);
        M2Done = 1'b1;
        stepCycles(1);
        checkOutput("normM2Drain", seq_stage, 1);
        checkOutput("normM1NotYet", M1_start, 0);
        stepCycles(1);
        checkOutput("normM1Pulse", M1_start, 1);
        checkOutput("normStageM1", seq_stage, 2);
        stepCycles(1);
        checkOutput("normM1PulseEnd", M1_start, 0);
        stepCycles(799);
        M1Done = 1'b1;
        stepCycles(1);
        checkOutput("normM1Drain", seq_stage, 2);
        checkOutput("normDoneEarly", seq_done, 0);
        stepCycles(1);
        checkOutput("normDonePulse", seq_done, 1);
        checkOutput("normDoneStage", seq_stage, 0);
        checkOutput("normDoneWe", SRAM_we_n, 1);
        stepCycles(1);
        checkOutput("normDoneEnd", seq_done, 0);
        checkOutput("normIdle", seq_busy, 0);
        checkOutput("normM2Count", m2StartSeen - m2Before, 1);
        checkOutput("normM1Count", m1StartSeen - m1Before, 1);
        checkOutput("normDoneCount", doneSeen - doneBefore, 1);
        checkOutput("normError", seq_error, 0);

        // Bypass with M1_done still high from the previous run
        m2Before = m2StartSeen; m1Before = m1StartSeen;
        doneBefore = doneSeen; stage1Before = stage1Seen;
        seqStart = 1'b1;
        skipM2   = 1'b1;
        stepCycles(1);
        checkOutput("byM1Pulse", M1_start, 1);
        checkOutput("byStage", seq_stage, 2);
        skipM2 = 1'b0;
        stepCycles(3);
        checkOutput("byIgnoreStart", seq_stage, 2);
        seqStart = 1'b0;
        stepCycles(20);
        checkOutput("staleBusy", seq_busy, 1);
        checkOutput("staleNoDone", doneSeen - doneBefore, 0);
        applyStimulus(18'h3FFFF, 16'hDEAD, 1'b0, 18'h12345, 16'hABCD, 1'b1);
        checkOutput("isoAddr", SRAM_address, 32'h12345);
        checkOutput("isoData", SRAM_write_data, 32'hABCD);
        checkOutput("isoWeN", SRAM_we_n, 1);
        applyStimulus(18'h3FFFF, 16'hDEAD, 1'b0, 18'h12345, 16'hABCD, 1'b0);
        checkOutput("isoM1Write", SRAM_we_n, 0);
        M1Done = 1'b0;
        stepCycles(1);
        checkOutput("staleFallStage", seq_stage, 2);
        M1Done = 1'b1;
        stepCycles(1);
        checkOutput("byDrain", seq_stage, 2);
        stepCycles(1);
        checkOutput("byDonePulse", seq_done, 1);
        checkOutput("byDoneWe", SRAM_we_n, 1);
        stepCycles(1);
        checkOutput("byNoM2Start", m2StartSeen - m2Before, 0);
        checkOutput("byNoStage1", stage1Seen - stage1Before, 0);
        checkOutput("byM1Count", m1StartSeen - m1Before, 1);
        checkOutput("byDoneCount", doneSeen - doneBefore, 1);

        // Reset in the middle of M1_RUN while M1 is writing
        M1Done   = 1'b0;
        seqStart = 1'b1;
        skipM2   = 1'b1;
        stepCycles(1);
        seqStart = 1'b0;
        skipM2   = 1'b0;
        stepCycles(1);
        checkOutput("midWriting", SRAM_we_n, 0);
        Resetn = 1'b0;
        #1;
        checkOutput("midWeN", SRAM_we_n, 1);
        checkOutput("midBusy", seq_busy, 0);
        checkOutput("midStage", seq_stage, 0);
        checkOutput("midAddr", SRAM_address, 0);
        checkOutput("midData", SRAM_write_data, 0);
        checkOutput("midM1Start", M1_start, 0);
        checkOutput("midDone", seq_done, 0);
        checkOutput("midError", seq_error, 0);
        stepCycles(2);
        Resetn = 1'b1;
        stepCycles(2);
        checkOutput("midRelM1Start", M1_start, 0);
        checkOutput("midRelWeN", SRAM_we_n, 1);

        // Watchdog timeout on the 100-cycle instance
        applyStimulus(18'h00055, 16'h5555, 1'b0, 18'h00066, 16'h6666, 1'b0);
        toDoneBefore = toDoneSeen;
        toStart = 1'b1;
        stepCycles(1);
        checkOutput("toM2Pulse", toM2Start, 1);
        checkOutput("toStageM2", toStage, 1);
        toStart = 1'b0;
        stepCycles(100);
        checkOutput("toBeforeLimitErr", toError, 0);
        checkOutput("toBeforeLimitBusy", toBusy, 1);
        stepCycles(1);
        checkOutput("toError", toError, 1);
        checkOutput("toIdle", toBusy, 0);
        checkOutput("toStage", toStage, 0);
        checkOutput("toWeN", toWeN, 1);
        stepCycles(3);
        checkOutput("toSticky", toError, 1);
        checkOutput("toNoDone", toDoneSeen - toDoneBefore, 0);

        // Restart clears the error; done edge on the limit cycle wins
        toStart = 1'b1;
        stepCycles(1);
        checkOutput("toErrCleared", toError, 0);
        toStart = 1'b0;
        stepCycles(100);
        toM2Done = 1'b1;
        stepCycles(1);
        checkOutput("tieNoError", toError, 0);
        checkOutput("tieDrain", toStage, 1);
        checkOutput("tieBusy", toBusy, 1);
        stepCycles(1);
        checkOutput("tieM1Pulse", toM1Start, 1);
        checkOutput("tieStageM1", toStage, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/decode_sequencer.md
DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 24'd10_000_000, per-stage watchdog limit (0.2 s at 50 MHz).
REQ-002 Port: CLOCK_50_I  in  1  50 MHz clock; the block's only clock.
REQ-003 Port: Resetn  in  1  asynchronous active-low reset.
REQ-004 Port: seq_start  in  1  request to run one decode; sampled only in S_SEQ_IDLE.
REQ-005 Port: skip_M2  in  1  bypass M2; sampled with seq_start.
REQ-006 Port: M2_start / M1_start  out  1 each  one-cycle start pulses to the M2 and M1 blocks.
REQ-007 Port: M2_done / M1_done  in  1 each  stage completion flags; level or pulse; held high after completion.
REQ-008 Port: M2_SRAM_address / M1_SRAM_address  in  18 each  requester addresses.
REQ-009 Port: M2_SRAM_write_data / M1_SRAM_write_data  in  16 each  requester write data.
REQ-010 Port: M2_SRAM_we_n / M1_SRAM_we_n  in  1 each  requester active-low write enables.
REQ-011 Port: SRAM_address / SRAM_write_data / SRAM_we_n  out  18/16/1  arbitrated SRAM port.
REQ-012 Port: seq_busy  out  1  high in every state except S_SEQ_IDLE.
REQ-013 Port: seq_done  out  1  one-cycle pulse on successful completion.
REQ-014 Port: seq_error  out  1  sticky watchdog flag; cleared by the next accepted seq_start.
REQ-015 Port: seq_stage  out  2  2'd0 none, 2'd1 M2 granted, 2'd2 M1 granted.

Function
REQ-016 States: S_SEQ_IDLE, S_SEQ_M2_START, S_SEQ_M2_RUN, S_SEQ_M2_DRAIN, S_SEQ_M1_START, S_SEQ_M1_RUN, S_SEQ_M1_DRAIN, S_SEQ_DONE.
REQ-017 IDLE + seq_start=1 -> M1_START if skip_M2=1, else M2_START; clear seq_error; clear watchdog.
REQ-018 M2_START: M2_start=1 for exactly this cycle -> M2_RUN. M1_START behaves the same with M1_start -> M1_RUN.
REQ-019 RUN states detect completion only on a rising edge of the stage done flag (registered previous value); a done level already high from a prior run is not accepted.
REQ-020 Rising edge of done in RUN -> DRAIN; DRAIN lasts exactly 1 cycle and keeps the grant so the stage's final write completes.
REQ-021 M2_DRAIN -> M1_START; M1_DRAIN -> DONE; DONE: seq_done=1 for one cycle -> IDLE.
REQ-022 Grant register: M2 in M2_START/RUN/DRAIN; M1 in M1_START/RUN/DRAIN; none elsewhere. seq_stage reflects the grant.
REQ-023 SRAM mux is combinational from the registered grant. With no grant: SRAM_we_n=1, SRAM_address=18'd0, SRAM_write_data=16'd0.
REQ-024 A non-granted requester's we_n=0 never reaches SRAM_we_n.
REQ-025 Watchdog: 24-bit counter, cleared on entering each START state, increments every RUN cycle.
REQ-026 Watchdog reaching TIMEOUT_CYCLES in RUN -> seq_error=1, grant none, IDLE; seq_done is not pulsed.
REQ-027 Done edge and timeout in the same cycle: done wins.
REQ-028 seq_start outside IDLE is ignored; no queuing.
REQ-029 A stage done edge while that stage is not granted is ignored.

Reset
REQ-030 Resetn=0 at any time, including mid-stage, forces IDLE, grant none, watchdog 0, done-edge registers 0.
REQ-031 Reset values: M1_start=0, M2_start=0, seq_busy=0, seq_done=0, seq_error=0, seq_stage=0, SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0.
REQ-032 Release of reset performs no SRAM write and emits no start pulse.

Structure
REQ-033 Place seq_state_type and the grant encoding in the shared state definition header, alongside the existing milestone state types.
REQ-034 Place the TIMEOUT_CYCLES default there as well.
REQ-035 Use one sub-module, sram_port_mux (grant + two requester buses -> SRAM bus). The FSM, watchdog and edge detect stay in decode_sequencer.

Verification
REQ-036 Normal run: seq_start=1, skip_M2=0; M2_done rises 500 cycles after M2_start; M1_done rises 800 cycles after M1_start -> one M2_start pulse, one M1_start pulse, seq_done exactly once, seq_error=0.
REQ-037 Bypass: seq_start=1, skip_M2=1 -> no M2_start; M1_start one cycle after start; seq_stage never 2'd1.
REQ-038 Isolation: in M1_RUN, drive M2_SRAM_we_n=0, M2_SRAM_address=18'h3FFFF -> SRAM_we_n and SRAM_address follow M1 only.
REQ-039 Stale done: M1_done held high from the previous run at the second seq_start -> no early completion; completion waits for a fresh 0->1 edge.
REQ-040 Timeout: TIMEOUT_CYCLES=24'd100, M2_done never rises -> seq_error=1 after 100 RUN cycles, IDLE, SRAM_we_n=1, no seq_done.
REQ-041 Mid-run reset: Resetn=0 in M1_RUN while M1_SRAM_we_n=0 -> SRAM_we_n=1 within reset, all outputs at reset values.
